// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the inst/data memory request arbiter: FSM states, owner encoding,
// latched request fields and the default starvation limit.
package mem_req_arbiter_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } mem_fields_t;

endpackage

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between an instruction and a data requester, one transaction at a
// time. Data has priority unless inst has been passed over STARVE_LIMIT times in a row.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        proto_err
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    mem_fields_t     fields_q, fields_d;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            proto_err_q, proto_err_d;
    // Low for the first cycle after reset release so a response from an abandoned
    // transaction is not flagged as a protocol error.
    logic            armed_q;

    logic grant;
    logic inst_wins;
    logic resp_done;

    always_comb begin
        // resetn gates grant so addr_ok stays low while reset is held.
        grant     = (state_q == IDLE) && resetn && (inst_req || data_req);
        inst_wins = inst_req && (!data_req || (starve_cnt_q == Limit));
        resp_done = (state_q == RESP) && mem_data_ok;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        fields_d     = fields_q;
        starve_cnt_d = starve_cnt_q;
        proto_err_d  = proto_err_q || (armed_q && mem_data_ok && (state_q != RESP));

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ADDR;
                    if (inst_wins) begin
                        owner_d      = OWN_INST;
                        fields_d     = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                                         wstrb: inst_wstrb, wdata: inst_wdata};
                        starve_cnt_d = '0;
                    end else begin
                        owner_d  = OWN_DATA;
                        fields_d = '{wr: data_wr, size: data_size, addr: data_addr,
                                     wstrb: data_wstrb, wdata: data_wdata};
                        if (!inst_req) begin
                            starve_cnt_d = '0;
                        end else if (starve_cnt_q != Limit) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            fields_q     <= '0;
            starve_cnt_q <= '0;
            proto_err_q  <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            fields_q     <= fields_d;
            starve_cnt_q <= starve_cnt_d;
            proto_err_q  <= proto_err_d;
            armed_q      <= 1'b1;
        end
    end

    always_comb begin
        inst_addr_ok = grant && inst_wins;
        data_addr_ok = grant && !inst_wins;
        inst_data_ok = resp_done && (owner_q == OWN_INST);
        data_data_ok = resp_done && (owner_q == OWN_DATA);
        inst_rdata   = inst_data_ok ? mem_rdata : '0;
        data_rdata   = data_data_ok ? mem_rdata : '0;

        mem_req      = (state_q == ADDR);
        mem_wr       = fields_q.wr;
        mem_size     = fields_q.size;
        mem_addr     = fields_q.addr;
        mem_wstrb    = fields_q.wstrb;
        mem_wdata    = fields_q.wdata;

        proto_err    = proto_err_q;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: vector table for basic transactions, a scoreboarded
// starvation run, and directed backpressure/write and reset/protocol-error sequences.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int unsigned Limit = 4;
    localparam logic [31:0] IAddr = 32'h1C00_0200;
    localparam logic [31:0] DAddr = 32'h1C00_0100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [3:0]  inst_wstrb;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        proto_err;

    mem_req_arbiter #(.STARVE_LIMIT(Limit)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ireq, dreq, maok, mdok;
        logic [31:0] mrd;
        logic        e_iaok, e_daok, e_idok, e_ddok, e_mreq;
        logic [31:0] e_rd;
        logic [31:0] e_maddr;
    } vec_t;

    function automatic vec_t mk(input logic ireq, input logic dreq, input logic maok,
                                input logic mdok, input logic [31:0] mrd,
                                input logic eia, input logic eda, input logic eid,
                                input logic edd, input logic emr,
                                input logic [31:0] erd, input logic [31:0] ema);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.maok = maok; v.mdok = mdok; v.mrd = mrd;
        v.e_iaok = eia; v.e_daok = eda; v.e_idok = eid; v.e_ddok = edd; v.e_mreq = emr;
        v.e_rd = erd; v.e_maddr = ema;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_iaok"}, 32'(inst_addr_ok), 0);
        check({tag, "_daok"}, 32'(data_addr_ok), 0);
        check({tag, "_idok"}, 32'(inst_data_ok), 0);
        check({tag, "_ddok"}, 32'(data_data_ok), 0);
        check({tag, "_irdata"}, inst_rdata, 0);
        check({tag, "_drdata"}, data_rdata, 0);
        check({tag, "_mreq"}, 32'(mem_req), 0);
        check({tag, "_maddr"}, mem_addr, 0);
        check({tag, "_mwr"}, 32'(mem_wr), 0);
        check({tag, "_mwstrb"}, 32'(mem_wstrb), 0);
        check({tag, "_mwdata"}, mem_wdata, 0);
        check({tag, "_perr"}, 32'(proto_err), 0);
    endtask

    vec_t   tbl[12];
    owner_e sb_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        string gstr;
        int    ngrant;
        int    phase;
        int    cnt;
        int    cyc;
        logic  exp_grant, exp_inst;
        owner_e own;

        resetn = 1'b0;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'b10; inst_addr = IAddr;
        inst_wstrb = 4'hF; inst_wdata = 32'hAAAA_0000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = DAddr;
        data_wstrb = 4'hF; data_wdata = 32'h5555_0000;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;

        // Outputs while held in reset, with both requests raised.
        @(negedge clk);
        #2;
        check_all_zero("rst0");
        @(negedge clk);
        resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0;

        //              ireq dreq maok mdok mrd            iaok daok idok ddok mreq rd   maddr
        tbl[0]  = mk(0, 1, 0, 0, 32'h0,          0, 1, 0, 0, 0, 32'h0,          32'h0);
        tbl[1]  = mk(0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 1, 32'h0,          DAddr);
        tbl[2]  = mk(0, 0, 0, 1, 32'hDEADBEEF,   0, 0, 0, 1, 0, 32'hDEADBEEF,   32'h0);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,          32'h0);
        tbl[4]  = mk(1, 1, 0, 0, 32'h0,          0, 1, 0, 0, 0, 32'h0,          32'h0);
        tbl[5]  = mk(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 1, 32'h0,          DAddr);
        tbl[6]  = mk(1, 0, 1, 0, 32'h0,          0, 0, 0, 0, 1, 32'h0,          DAddr);
        tbl[7]  = mk(1, 0, 0, 1, 32'hCAFEF00D,   0, 0, 0, 1, 0, 32'hCAFEF00D,   32'h0);
        tbl[8]  = mk(1, 0, 0, 0, 32'h0,          1, 0, 0, 0, 0, 32'h0,          32'h0);
        tbl[9]  = mk(0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 1, 32'h0,          IAddr);
        tbl[10] = mk(0, 0, 0, 1, 32'h0BADC0DE,   0, 0, 1, 0, 0, 32'h0BADC0DE,   32'h0);
        tbl[11] = mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 32'h0,          32'h0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            inst_req = tbl[i].ireq; data_req = tbl[i].dreq;
            mem_addr_ok = tbl[i].maok; mem_data_ok = tbl[i].mdok; mem_rdata = tbl[i].mrd;
            #2;
            check($sformatf("vec%0d_iaok", i), 32'(inst_addr_ok), 32'(tbl[i].e_iaok));
            check($sformatf("vec%0d_daok", i), 32'(data_addr_ok), 32'(tbl[i].e_daok));
            check($sformatf("vec%0d_idok", i), 32'(inst_data_ok), 32'(tbl[i].e_idok));
            check($sformatf("vec%0d_ddok", i), 32'(data_data_ok), 32'(tbl[i].e_ddok));
            check($sformatf("vec%0d_irdata", i), inst_rdata, tbl[i].e_idok ? tbl[i].e_rd : 0);
            check($sformatf("vec%0d_drdata", i), data_rdata, tbl[i].e_ddok ? tbl[i].e_rd : 0);
            check($sformatf("vec%0d_mreq", i), 32'(mem_req), 32'(tbl[i].e_mreq));
            if (tbl[i].e_mreq) begin
                check($sformatf("vec%0d_maddr", i), mem_addr, tbl[i].e_maddr);
            end
        end
        check("tbl_perr", 32'(proto_err), 0);

        // Starvation: both requesters held high; memory answers as fast as allowed.
        gstr = ""; ngrant = 0; phase = 0; cnt = 0; cyc = 0;
        while (!(ngrant == 10 && phase == 0) && cyc < 200) begin
            cyc++;
            @(negedge clk);
            inst_req = (ngrant < 10); data_req = (ngrant < 10);
            mem_addr_ok = 1'b1; mem_data_ok = (phase == 2); mem_rdata = $urandom;
            #2;
            exp_grant = (phase == 0) && (inst_req || data_req);
            exp_inst  = inst_req && (!data_req || cnt == int'(Limit));
            check("sv_iaok", 32'(inst_addr_ok), 32'(exp_grant && exp_inst));
            check("sv_daok", 32'(data_addr_ok), 32'(exp_grant && !exp_inst));
            check("sv_mreq", 32'(mem_req), 32'(phase == 1));
            if (exp_grant) begin
                sb_q.push_back(exp_inst ? OWN_INST : OWN_DATA);
                if (inst_addr_ok) gstr = {gstr, "I"};
                else if (data_addr_ok) gstr = {gstr, "D"};
                if (exp_inst) cnt = 0;
                else if (!inst_req) cnt = 0;
                else if (cnt < int'(Limit)) cnt++;
                ngrant++;
                phase = 1;
            end else if (phase == 1) begin
                phase = 2;
            end else if (phase == 2) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    own = sb_q.pop_front();
                    check("sb_idok", 32'(inst_data_ok), 32'(own == OWN_INST));
                    check("sb_ddok", 32'(data_data_ok), 32'(own == OWN_DATA));
                    check("sb_irdata", inst_rdata, (own == OWN_INST) ? mem_rdata : 0);
                    check("sb_drdata", data_rdata, (own == OWN_DATA) ? mem_rdata : 0);
                end
                phase = 0;
            end
        end
        check("sv_budget", 32'(cyc < 200), 1);
        check("sv_sb_empty", sb_q.size(), 0);
        checks++;
        if (gstr != "DDDDIDDDDI") begin
            errors++;
            $display("FAIL sv_order: got %s expected DDDDIDDDDI", gstr);
        end

        // Backpressured write: fields must stay latched while mem_addr_ok is withheld.
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
        data_wdata = 32'h1234_5678; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        #2;
        check("wr_daok", 32'(data_addr_ok), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
            data_wstrb = 4'hC; data_wdata = $urandom; data_addr = DAddr + 32'(4 * (i + 1));
            #2;
            check($sformatf("bp%0d_iaok", i), 32'(inst_addr_ok), 0);
            check($sformatf("bp%0d_daok", i), 32'(data_addr_ok), 0);
            check($sformatf("bp%0d_mreq", i), 32'(mem_req), 1);
            check($sformatf("bp%0d_maddr", i), mem_addr, DAddr);
            check($sformatf("bp%0d_mwdata", i), mem_wdata, 32'h1234_5678);
            check($sformatf("bp%0d_mwstrb", i), 32'(mem_wstrb), 32'h3);
            check($sformatf("bp%0d_mwr", i), 32'(mem_wr), 1);
        end
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; data_addr = DAddr; data_wstrb = 4'hF;
        mem_addr_ok = 1'b1;
        #2;
        check("wr_mreq_accept", 32'(mem_req), 1);
        @(negedge clk);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0;
        #2;
        check("wr_ddok", 32'(data_data_ok), 1);
        check("wr_idok", 32'(inst_data_ok), 0);
        check("wr_mreq_low", 32'(mem_req), 0);
        @(negedge clk);
        mem_data_ok = 1'b0;

        // Reset asserted while a read waits in RESP.
        @(negedge clk);
        data_req = 1'b1;
        @(negedge clk);
        data_req = 1'b0; mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        #2;
        resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1;
        #1;
        check_all_zero("rst1");
        @(negedge clk);
        resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        #2;
        check("late_idok", 32'(inst_data_ok), 0);
        check("late_ddok", 32'(data_data_ok), 0);
        @(negedge clk);
        mem_data_ok = 1'b0;
        #2;
        check("late_perr", 32'(proto_err), 0);
        @(negedge clk);
        mem_data_ok = 1'b1;
        #2;
        check("stray_idok", 32'(inst_data_ok), 0);
        check("stray_ddok", 32'(data_data_ok), 0);
        @(negedge clk);
        mem_data_ok = 1'b0;
        #2;
        check("stray_perr", 32'(proto_err), 1);
        @(negedge clk);
        #2;
        check("sticky_perr", 32'(proto_err), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
